// File: rtl/somatorio_pkg.sv
// Shared types and helpers for the somatorio datapath.
package somatorio_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcum = 2'd1,
        StFim  = 2'd2
    } estado_t;

    // Wide enough for any practical WIDTH; callers keep the low WIDTH bits.
    typedef struct packed {
        logic [63:0] max_v;
        logic [63:0] min_v;
    } sat_limits_t;

    // Two's-complement limits for a signed value of the given width.
    function automatic sat_limits_t sat_limits(input int unsigned width);
        sat_limits_t lim;
        lim.max_v = (64'd1 << (width - 1)) - 64'd1;
        // -2^(w-1) is the bitwise complement of 2^(w-1)-1.
        lim.min_v = ~lim.max_v;
        return lim;
    endfunction

endpackage

// File: rtl/somador_sat.sv
// Combinational signed adder with optional saturation and overflow detect.
module somador_sat
    import somatorio_pkg::*;
#(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] soma,
    output logic             ovf_step
);

    localparam sat_limits_t     Lim    = sat_limits(WIDTH);
    localparam logic [63:0]     LimMax = Lim.max_v;
    localparam logic [63:0]     LimMin = Lim.min_v;
    localparam logic [WIDTH-1:0] MaxV  = LimMax[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MinV  = LimMin[WIDTH-1:0];

    logic [WIDTH-1:0] raw;

    // Raw sum, overflow when same-sign operands produce a different-sign result.
    always_comb begin
        raw      = a + b;
        ovf_step = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        soma     = raw;
        if ((SATURATE != 0) && ovf_step) begin
            soma = a[WIDTH-1] ? MinV : MaxV;
        end
    end

endmodule

// File: rtl/somador_sequencial_param.sv
// Sequential signed accumulator: sums NUM_TERMS handshaked samples per start.
module somador_sequencial_param
    import somatorio_pkg::*;
#(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned NUM_TERMS = 3,
    parameter int unsigned SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic [WIDTH-1:0] valor,
    input  logic             valor_valido,
    output logic             valor_pronto,
    output logic             pronto,
    output logic             concluido,
    output logic [WIDTH-1:0] soma,
    output logic             overflow
);

    localparam int unsigned     CntW    = $clog2(NUM_TERMS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_TERMS - 1);

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] soma_q, soma_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] acc_sum;
    logic             ovf_step;

    somador_sat #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_somador_sat (
        .a        (acc_q),
        .b        (valor),
        .soma     (acc_sum),
        .ovf_step (ovf_step)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            soma_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            soma_q     <= soma_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state and datapath update; everything holds unless a transition acts.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        soma_d     = soma_q;
        overflow_d = overflow_q;
        case (state_q)
            StIdle: begin
                if (inicio) begin
                    state_d   = StAcum;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    count_d   = '0;
                end
            end
            StAcum: begin
                if (valor_valido) begin
                    acc_d     = acc_sum;
                    ovf_acc_d = ovf_acc_q | ovf_step;
                    count_d   = count_q + CntW'(1);
                    if (count_q == LastCnt) begin
                        state_d    = StFim;
                        soma_d     = acc_sum;
                        overflow_d = ovf_acc_q | ovf_step;
                    end
                end
            end
            StFim: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        pronto       = (state_q == StIdle);
        valor_pronto = (state_q == StAcum);
        concluido    = (state_q == StFim);
        soma         = soma_q;
        overflow     = overflow_q;
    end

endmodule

// File: tb/tb_somador_sequencial_param.sv
// Bench for somador_sequencial_param: wrap, saturate and single-term instances.
module tb_somador_sequencial_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Shared stimulus for the two 6-bit, 3-term instances.
    logic       inicio, valor_valido;
    logic [5:0] valor;
    logic       vp0, pr0, cc0, ov0;
    logic [5:0] sm0;
    logic       vp1, pr1, cc1, ov1;
    logic [5:0] sm1;

    // Single-term 8-bit instance.
    logic       inicio2, valido2;
    logic [7:0] valor2;
    logic       vp2, pr2, cc2, ov2;
    logic [7:0] sm2;

    somador_sequencial_param #(.WIDTH(6), .NUM_TERMS(3), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .inicio(inicio), .valor(valor),
        .valor_valido(valor_valido), .valor_pronto(vp0), .pronto(pr0),
        .concluido(cc0), .soma(sm0), .overflow(ov0)
    );

    somador_sequencial_param #(.WIDTH(6), .NUM_TERMS(3), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .inicio(inicio), .valor(valor),
        .valor_valido(valor_valido), .valor_pronto(vp1), .pronto(pr1),
        .concluido(cc1), .soma(sm1), .overflow(ov1)
    );

    somador_sequencial_param #(.WIDTH(8), .NUM_TERMS(1), .SATURATE(0)) dut_one (
        .clk(clk), .reset(reset), .inicio(inicio2), .valor(valor2),
        .valor_valido(valido2), .valor_pronto(vp2), .pronto(pr2),
        .concluido(cc2), .soma(sm2), .overflow(ov2)
    );

    typedef struct {
        int soma;
        bit ovf;
        int t0;
        int lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    typedef struct {
        int a;
        int b;
        int c;
        int stall;
        int w_soma;
        bit w_ovf;
        int s_soma;
        bit s_ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic spurious(input string name);
        checks++;
        errors++;
        $display("FAIL %s: concluido pulse with no operation pending (t=%0t)", name, $time);
    endtask

    task automatic cmp_done(input string tag, input int s, input int o, input exp_t e);
        chk({tag, "_soma"}, s, e.soma);
        chk({tag, "_overflow"}, o, int'(e.ovf));
        chk({tag, "_latency"}, cyc - e.t0, e.lat);
    endtask

    // Scoreboard monitors: pop an expectation on every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (cc0 === 1'b1) begin
            if (q0.size() == 0) spurious("wrap_spurious");
            else begin
                e = q0.pop_front();
                cmp_done("wrap", int'($signed(sm0)), int'(ov0), e);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cc1 === 1'b1) begin
            if (q1.size() == 0) spurious("sat_spurious");
            else begin
                e = q1.pop_front();
                cmp_done("sat", int'($signed(sm1)), int'(ov1), e);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cc2 === 1'b1) begin
            if (q2.size() == 0) spurious("one_spurious");
            else begin
                e = q2.pop_front();
                cmp_done("one", int'($signed(sm2)), int'(ov2), e);
            end
        end
    end

    task automatic push_exp(input int which, input int s, input bit o, input int t0, input int lat);
        exp_t e;
        e.soma = s;
        e.ovf  = o;
        e.t0   = t0;
        e.lat  = lat;
        if (which == 0) q0.push_back(e);
        else if (which == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    // One 3-sample operation on both 6-bit instances, optional stall cycles between samples.
    task automatic run_vec(input vec_t v);
        int s[3];
        int t0;
        s[0] = v.a;
        s[1] = v.b;
        s[2] = v.c;
        @(negedge clk);
        chk("pronto_before_op", int'(pr0), 1);
        inicio = 1'b1;
        t0 = cyc;
        push_exp(0, v.w_soma, v.w_ovf, t0, 4 + 2 * v.stall);
        push_exp(1, v.s_soma, v.s_ovf, t0, 4 + 2 * v.stall);
        @(negedge clk);
        inicio = 1'b0;
        chk("valor_pronto_acum", int'(vp0), 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                for (int k = 0; k < v.stall; k++) begin
                    valor_valido = 1'b0;
                    @(negedge clk);
                    chk("valor_pronto_stall", int'(vp0), 1);
                end
            end
            valor        = 6'(s[i]);
            valor_valido = 1'b1;
            @(negedge clk);
        end
        valor_valido = 1'b0;
        chk("concluido_in_fim", int'(cc0), 1);
        @(negedge clk);
        chk("concluido_one_cycle", int'(cc0), 0);
        chk("pronto_after_fim", int'(pr0), 1);
    endtask

    vec_t vecs[6];

    initial begin
        int t0;
        reset        = 1'b1;
        inicio       = 1'b0;
        valor        = '0;
        valor_valido = 1'b0;
        inicio2      = 1'b0;
        valor2       = '0;
        valido2      = 1'b0;

        //         a    b    c  stall wrap      sat
        vecs[0] = '{5,   7,   -2, 0,  10,  1'b0, 10,  1'b0};
        vecs[1] = '{30,  10,  -20, 0, 20,  1'b1, 11,  1'b1};
        vecs[2] = '{-30, -10, -5, 0,  19,  1'b1, -32, 1'b1};
        vecs[3] = '{1,   2,   3,  2,  6,   1'b0, 6,   1'b0};
        vecs[4] = '{31,  1,   -1, 0,  31,  1'b1, 30,  1'b1};
        vecs[5] = '{-32, -1,  0,  1,  31,  1'b1, -32, 1'b1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_pronto", int'(pr0), 1);
        chk("reset_valor_pronto", int'(vp0), 0);
        chk("reset_concluido", int'(cc0), 0);
        chk("reset_soma", int'(sm0), 0);
        chk("reset_overflow", int'(ov0), 0);
        chk("reset_one_pronto", int'(pr2), 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset after the second accepted sample: immediate abort, no completion.
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        inicio       = 1'b0;
        valor        = 6'd10;
        valor_valido = 1'b1;
        repeat (2) @(negedge clk);
        valor_valido = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_pronto", int'(pr0), 1);
        chk("abort_valor_pronto", int'(vp0), 0);
        chk("abort_soma", int'(sm0), 0);
        chk("abort_overflow", int'(ov0), 0);
        chk("abort_sat_soma", int'(sm1), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_idle", int'(pr0), 1);

        // inicio held high: no restart during ACUM/FIM, restart from IDLE only.
        @(negedge clk);
        inicio       = 1'b1;
        valor        = 6'd1;
        valor_valido = 1'b1;
        t0 = cyc;
        push_exp(0, 3, 1'b0, t0, 4);
        push_exp(1, 3, 1'b0, t0, 4);
        repeat (4) @(negedge clk);
        chk("held_concluido", int'(cc0), 1);
        @(negedge clk);
        chk("held_back_to_idle", int'(pr0), 1);
        chk("held_no_restart_in_fim", int'(vp0), 0);
        t0 = cyc;
        push_exp(0, 6, 1'b0, t0, 4);
        push_exp(1, 6, 1'b0, t0, 4);
        valor = 6'd2;
        @(negedge clk);
        chk("held_restart", int'(vp0), 1);
        inicio = 1'b0;
        repeat (3) @(negedge clk);
        valor_valido = 1'b0;
        @(negedge clk);
        chk("held_second_done", int'(pr0), 1);

        // Single-term, 8-bit instance.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            inicio2 = 1'b1;
            push_exp(2, (i == 0) ? 127 : -128, 1'b0, cyc, 2);
            @(negedge clk);
            inicio2 = 1'b0;
            chk("one_valor_pronto", int'(vp2), 1);
            valor2  = (i == 0) ? 8'd127 : 8'h80;
            valido2 = 1'b1;
            @(negedge clk);
            valido2 = 1'b0;
            @(negedge clk);
            chk("one_pronto_after", int'(pr2), 1);
        end

        repeat (3) @(negedge clk);
        chk("wrap_all_completed", q0.size(), 0);
        chk("sat_all_completed", q1.size(), 0);
        chk("one_all_completed", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
